// File: rtl/huff_merge_ctrl_pkg.sv
// Shared definitions for the Huffman merge controller and its merge PE:
// node word layout, symbol count, code width and FSM encoding.
package huff_merge_ctrl_pkg;

  localparam int NSYM    = 6;
  localparam int CW      = 8;
  localparam int NODE_W  = 15;
  localparam int CNT_HI  = 14;
  localparam int CNT_LO  = 7;
  localparam int FLAG_HI = 5;

  localparam logic [7:0]        MAX_PIX    = 8'd254;
  localparam logic [NODE_W-1:0] EMPTY_NODE = 15'h7FFF;

  typedef logic [NODE_W-1:0] node_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic node_t make_node(input logic [7:0] cnt, input logic [FLAG_HI:0] flag);
    node_t n;
    n = '0;
    n[CNT_HI:CNT_LO] = cnt;
    n[FLAG_HI:0]     = flag;
    return n;
  endfunction

endpackage

// File: rtl/huff_merge_ctrl_if.sv
// Pixel stream, PE node/result bus and histogram/code outputs of the merge controller.
interface huff_merge_ctrl_if;
  import huff_merge_ctrl_pkg::*;

  logic                        in_valid;
  logic [2:0]                  in_sym;
  logic                        in_last;
  logic [NSYM:1][NODE_W-1:0]   pe_cnt;
  logic [NSYM:1][NODE_W-1:0]   pe_cnt_n;
  logic [7:0]                  pe_sum;
  logic [6:0]                  pe_flag;
  logic                        cnt_valid;
  logic [NSYM:1][7:0]          cnt;
  logic                        code_valid;
  logic [NSYM:1][CW-1:0]       hc;
  logic [NSYM:1][CW-1:0]       m;
  logic                        ovf;

  modport master (
    output in_valid, in_sym, in_last, pe_cnt_n, pe_sum, pe_flag,
    input  pe_cnt, cnt_valid, cnt, code_valid, hc, m, ovf
  );

  modport slave (
    input  in_valid, in_sym, in_last, pe_cnt_n, pe_sum, pe_flag,
    output pe_cnt, cnt_valid, cnt, code_valid, hc, m, ovf
  );

endinterface

// File: rtl/huff_code_acc.sv
// Per-symbol code accumulator: each merge that touches the symbol appends one
// code bit (1 = min side, 0 = 2nd-min side) above the bits already built.
module huff_code_acc
  import huff_merge_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic          i_min,
  input  logic          i_2nd,
  output logic [CW-1:0] o_hc,
  output logic [CW-1:0] o_mask
);

  localparam int LW = $clog2(CW);

  logic [LW-1:0] r_len;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_mask;
  logic          w_step;

  // A full mask means the length has saturated at CW.
  assign w_step = i_en && (i_min || i_2nd) && !r_mask[CW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_hc   <= '0;
      r_mask <= '0;
    end else if (i_clear) begin
      r_len  <= '0;
      r_hc   <= '0;
      r_mask <= '0;
    end else if (w_step) begin
      r_hc[r_len] <= i_min;
      r_mask      <= {r_mask[CW-2:0], 1'b1};
      r_len       <= r_len + LW'(1);
    end
  end

  assign o_hc   = r_hc;
  assign o_mask = r_mask;

endmodule

// File: rtl/huff_merge_ctrl.sv
// Histogram + merge sequencer in front of the combinational Huffman merge PE:
// counts a pixel frame, loads six leaf nodes, runs five merges, builds codes.
module huff_merge_ctrl
  import huff_merge_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  huff_merge_ctrl_if.slave  bus
);

  localparam logic [2:0] LAST_STEP = 3'(NSYM - 2);

  logic [2:0] r_state;
  logic [2:0] r_step;
  logic [7:0] r_total;
  logic       r_ovf;
  logic       r_cnt_valid;
  logic       r_code_valid;

  logic w_sym_ok;
  logic w_accept;
  logic w_start;
  logic w_end;
  logic w_count;
  logic w_merge;
  logic w_unused;

  assign w_sym_ok = (bus.in_sym != 3'd0) && (bus.in_sym != 3'd7);
  assign w_accept = bus.in_valid && ((r_state == S_IDLE) || (r_state == S_COUNT));
  assign w_start  = bus.in_valid && (r_state == S_IDLE);
  assign w_end    = w_accept && bus.in_last;
  assign w_count  = w_accept && w_sym_ok && (w_start || (r_total != MAX_PIX));
  assign w_merge  = (r_state == S_MERGE);

  // Only the flag fields of the two minima drive code updates.
  assign w_unused = ^{bus.pe_flag[6], bus.pe_cnt_n[NSYM][NODE_W-1:FLAG_HI+1],
                      bus.pe_cnt_n[NSYM-1][NODE_W-1:FLAG_HI+1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.in_valid) r_state <= bus.in_last ? S_LOAD : S_COUNT;
        S_COUNT: if (w_end) r_state <= S_LOAD;
        S_LOAD: begin
          r_state <= S_MERGE;
          r_step  <= '0;
        end
        S_MERGE: begin
          if (r_step == LAST_STEP) r_state <= S_DONE;
          else                     r_step  <= r_step + 3'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The total cap keeps every merged sum below 255, so pe_sum never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total      <= '0;
      r_ovf        <= 1'b0;
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      r_cnt_valid  <= w_end;
      r_code_valid <= w_merge && (r_step == LAST_STEP);
      if (w_start) begin
        r_total <= {7'd0, w_sym_ok};
        r_ovf   <= 1'b0;
      end else if (w_count) begin
        r_total <= r_total + 8'd1;
      end else if (w_accept && w_sym_ok) begin
        r_ovf <= 1'b1;
      end
    end
  end

  for (genvar gi = 1; gi <= NSYM; gi++) begin : g_sym
    localparam logic [FLAG_HI:0] ONEHOT = {{FLAG_HI{1'b0}}, 1'b1} << (gi - 1);

    logic [7:0] r_cnt;
    node_t      r_node;
    node_t      w_node_next;
    logic       w_hit;

    assign w_hit = w_sym_ok && (bus.in_sym == 3'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_cnt <= '0;
      else if (w_start)          r_cnt <= {7'd0, w_hit};
      else if (w_count && w_hit) r_cnt <= r_cnt + 8'd1;
    end

    // Nodes 1..4 keep the PE survivors, node 5 takes the new parent, node 6 retires.
    if (gi <= NSYM - 2) begin : g_keep
      assign w_node_next = bus.pe_cnt_n[gi];
    end else if (gi == NSYM - 1) begin : g_sum
      assign w_node_next = make_node(bus.pe_sum, bus.pe_flag[FLAG_HI:0]);
    end else begin : g_empty
      assign w_node_next = EMPTY_NODE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_node <= '0;
      else if (r_state == S_LOAD)   r_node <= make_node(r_cnt, ONEHOT);
      else if (w_merge)             r_node <= w_node_next;
    end

    huff_code_acc u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_start),
      .i_en    (w_merge),
      .i_min   (bus.pe_cnt_n[NSYM][gi-1]),
      .i_2nd   (bus.pe_cnt_n[NSYM-1][gi-1]),
      .o_hc    (bus.hc[gi]),
      .o_mask  (bus.m[gi])
    );

    assign bus.cnt[gi]    = r_cnt;
    assign bus.pe_cnt[gi] = r_node;
  end

  assign bus.cnt_valid  = r_cnt_valid;
  assign bus.code_valid = r_code_valid;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_huff_merge_ctrl.sv
// Directed bench for huff_merge_ctrl with a behavioural merge PE beside it.
module tb_huff_merge_ctrl;
  import huff_merge_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  huff_merge_ctrl_if bus();

  huff_merge_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: ascending sort of the six node words.
  function automatic logic [5:0][14:0] sort6(input logic [5:0][14:0] a);
    logic [5:0][14:0] s;
    logic [14:0]      t;
    s = a;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s;
  endfunction

  logic [5:0][14:0] srt;
  logic [8:0]       sum9;
  assign srt          = sort6(bus.pe_cnt);
  assign bus.pe_cnt_n = {srt[0], srt[1], srt[5], srt[4], srt[3], srt[2]};
  assign bus.pe_sum   = srt[0][14:7] + srt[1][14:7];
  assign bus.pe_flag  = srt[0][6:0] | srt[1][6:0];
  assign sum9         = {1'b0, srt[0][14:7]} + {1'b0, srt[1][14:7]};

  typedef struct {
    string            name;
    logic             junk;
    logic [5:0][8:0]  n;
    logic [5:0][7:0]  cnt;
    logic [5:0][7:0]  hc;
    logic [5:0][7:0]  m;
    logic             ovf;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic send_pix(input logic [2:0] sym, input logic last);
    bus.in_valid = 1'b1;
    bus.in_sym   = sym;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sym   = 3'd0;
  endtask

  task automatic stream(input logic [5:0][8:0] n, input logic junk);
    int rem[6];
    int total;
    int sent;
    total = 0;
    sent  = 0;
    for (int s = 0; s < 6; s++) begin
      rem[s] = int'(n[s]);
      total += rem[s];
    end
    while (sent < total) begin
      for (int s = 0; s < 6; s++) begin
        if (rem[s] > 0) begin
          rem[s]--;
          sent++;
          send_pix(3'(s + 1), sent == total);
          if (junk && sent < total) send_pix(sent[0] ? 3'd7 : 3'd0, 1'b0);
        end
      end
    end
  endtask

  // Bounded wait for code_valid; optionally keeps in_valid high to show it is ignored.
  task automatic wait_code(input logic hold_valid, output int lat, output int max_sum);
    lat     = 0;
    max_sum = 0;
    bus.in_valid = hold_valid;
    bus.in_sym   = 3'd1;
    bus.in_last  = hold_valid;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.code_valid) break;
      if (int'(sum9) > max_sum) max_sum = int'(sum9);
    end
    bus.in_valid = 1'b0;
    bus.in_sym   = 3'd0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input int i);
    int lat;
    int mx;
    stream(tbl[i].n, tbl[i].junk);
    check({tbl[i].name, "_cnt_valid"}, 64'(bus.cnt_valid), 64'd1);
    for (int s = 1; s <= 6; s++)
      check($sformatf("%s_cnt%0d", tbl[i].name, s), 64'(bus.cnt[s]), 64'(tbl[i].cnt[s-1]));
    check({tbl[i].name, "_ovf"}, 64'(bus.ovf), 64'(tbl[i].ovf));
    wait_code(tbl[i].junk, lat, mx);
    check({tbl[i].name, "_code_latency"}, 64'(lat), 64'd6);
    check({tbl[i].name, "_sum_below_255"}, 64'(mx < 255), 64'd1);
    for (int s = 1; s <= 6; s++) begin
      check($sformatf("%s_hc%0d", tbl[i].name, s), 64'(bus.hc[s]), 64'(tbl[i].hc[s-1]));
      check($sformatf("%s_m%0d", tbl[i].name, s), 64'(bus.m[s]), 64'(tbl[i].m[s-1]));
    end
    @(posedge clk); #1;
    check({tbl[i].name, "_code_valid_pulse"}, 64'(bus.code_valid), 64'd0);
    check({tbl[i].name, "_cnt_hold"}, 64'(bus.cnt), 64'(tbl[i].cnt));
    $display("frame %s lat=%0d max_sum=%0d hc=%h m=%h", tbl[i].name, lat, mx, bus.hc, bus.m);
  endtask

  initial begin
    int lat;
    int mx;
    n_checks = 0;
    n_fail   = 0;

    tbl[0].name = "t1_base";
    tbl[0].junk = 1'b0;
    tbl[0].n    = {9'd35, 9'd25, 9'd18, 9'd12, 9'd7, 9'd3};
    tbl[0].cnt  = {8'd35, 8'd25, 8'd18, 8'd12, 8'd7, 8'd3};
    tbl[0].hc   = {8'b00, 8'b01, 8'b11, 8'b100, 8'b1010, 8'b1011};
    tbl[0].m    = {8'h03, 8'h03, 8'h03, 8'h07, 8'h0F, 8'h0F};
    tbl[0].ovf  = 1'b0;

    tbl[1]      = tbl[0];
    tbl[1].name = "t2_junk";
    tbl[1].junk = 1'b1;

    tbl[2].name = "t5_single";
    tbl[2].junk = 1'b0;
    tbl[2].n    = {9'd0, 9'd0, 9'd1, 9'd0, 9'd0, 9'd0};
    tbl[2].cnt  = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    tbl[2].hc   = {8'b10, 8'b110, 8'b0, 8'b1110, 8'b11110, 8'b11111};
    tbl[2].m    = {8'h03, 8'h07, 8'h01, 8'h0F, 8'h1F, 8'h1F};
    tbl[2].ovf  = 1'b0;

    tbl[3].name = "t3_ovf";
    tbl[3].junk = 1'b0;
    tbl[3].n    = {9'd0, 9'd0, 9'd0, 9'd260, 9'd0, 9'd0};
    tbl[3].cnt  = {8'd0, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0};
    tbl[3].hc   = {8'b10, 8'b110, 8'b1110, 8'b0, 8'b11110, 8'b11111};
    tbl[3].m    = {8'h03, 8'h07, 8'h0F, 8'h01, 8'h1F, 8'h1F};
    tbl[3].ovf  = 1'b1;

    bus.in_valid = 1'b0;
    bus.in_sym   = 3'd0;
    bus.in_last  = 1'b0;
    rst_n        = 1'b0;
    #12;
    check("reset_cnt",        64'(bus.cnt), 64'd0);
    check("reset_hc",         64'(bus.hc), 64'd0);
    check("reset_m",          64'(bus.m), 64'd0);
    check("reset_pe_cnt",     64'(|bus.pe_cnt), 64'd0);
    check("reset_flags",      64'({bus.cnt_valid, bus.code_valid, bus.ovf}), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_frame(i);

    // Back-to-back: first pixel of a new frame wipes the previous results and ovf.
    send_pix(3'd2, 1'b0);
    check("b2b_hc_cleared",  64'(bus.hc), 64'd0);
    check("b2b_m_cleared",   64'(bus.m), 64'd0);
    check("b2b_cnt_fresh",   64'(bus.cnt), 64'h0000_0000_0100);
    check("b2b_ovf_cleared", 64'(bus.ovf), 64'd0);
    send_pix(3'd2, 1'b1);
    check("b2b_cnt2", 64'(bus.cnt[2]), 64'd2);
    wait_code(1'b0, lat, mx);
    check("b2b_code_latency", 64'(lat), 64'd6);
    @(posedge clk); #1;
    $display("frame b2b lat=%0d", lat);

    // Reset asserted during merge step 2 clears everything at once.
    stream(tbl[0].n, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cnt",    64'(bus.cnt), 64'd0);
    check("midrst_hc",     64'(bus.hc), 64'd0);
    check("midrst_m",      64'(bus.m), 64'd0);
    check("midrst_pe_cnt", 64'(|bus.pe_cnt), 64'd0);
    check("midrst_flags",  64'({bus.cnt_valid, bus.code_valid, bus.ovf}), 64'd0);
    $display("frame midrst aborted");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
